// File: rtl/store_unit.sv
// Store path from the register file to data memory: lane-shifts rs2, builds byte enables, runs req/gnt/ack.
// Build option STORE_MISALIGN_TRAP_EN: misaligned SH/SW raise st_err instead of being force-aligned.
`ifndef REG_LEN
`define REG_LEN 32
`endif

module store_unit #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                st_valid_i,
   output logic                st_ready_o,
   input  logic [ADDR_W-1:0]   st_addr_i,
   input  logic [`REG_LEN-1:0] st_data_i,
   input  logic [1:0]          st_size_i,
   output logic                st_done_o,
   output logic                st_err_o,
   output logic                mem_req_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [`REG_LEN-1:0] mem_wdata_o,
   output logic [3:0]          mem_be_o,
   input  logic                mem_gnt_i,
   input  logic                mem_ack_i
);

   localparam int DATA_W = `REG_LEN;
   localparam int TMR_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [1:0]        laneOff;
   logic [3:0]        reqBe;
   logic [DATA_W-1:0] reqWdata;
   logic              reqBad;
   logic              timeoutHit;

   // Decode the incoming request into lane-shifted data and byte enables.
   always_comb begin
      laneOff  = st_addr_i[1:0];
      reqBe    = 4'b0000;
      reqWdata = '0;
      reqBad   = 1'b0;
      case (st_size_i)
         SZ_B: begin
            reqBe    = 4'b0001 << laneOff;
            reqWdata = {4{st_data_i[7:0]}};
         end
         SZ_H: begin
`ifdef STORE_MISALIGN_TRAP_EN
            reqBad   = laneOff[0];
            reqBe    = 4'b0011 << laneOff;
`else
            reqBe    = 4'b0011 << (laneOff & 2'b10);
`endif
            reqWdata = {2{st_data_i[15:0]}};
         end
         SZ_W: begin
`ifdef STORE_MISALIGN_TRAP_EN
            reqBad   = (laneOff != 2'b00);
`endif
            reqBe    = 4'b1111;
            reqWdata = st_data_i;
         end
         default: begin
            reqBad   = 1'b1;
         end
      endcase
   end

   // A disabled timeout (TIMEOUT_CYC == 0) never fires; the timer then sits at zero.
   assign timeoutHit = (TIMEOUT_CYC != 0) && (tmr_q == TMR_W'(TIMEOUT_CYC));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      tmr_d   = tmr_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (st_valid_i) begin
               if (reqBad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_REQ;
                  addr_d  = {st_addr_i[ADDR_W-1:2], 2'b00};
                  wdata_d = reqWdata;
                  be_d    = reqBe;
               end
            end
         end
         S_REQ: begin
            if (mem_gnt_i) begin
               if (mem_ack_i) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  tmr_d   = '0;
               end
            end
         end
         S_WAIT: begin
            // Ack wins over a timeout landing in the same cycle.
            if (mem_ack_i) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (timeoutHit) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else if (tmr_q != TMR_W'(TIMEOUT_CYC)) begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= 4'b0000;
         tmr_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         tmr_q   <= tmr_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign st_ready_o  = (state_q == S_IDLE);
   assign mem_req_o   = (state_q == S_REQ);
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;
   assign st_done_o   = done_q;
   assign st_err_o    = err_q;

endmodule
